// File: rtl/stream_split.sv
// stream_split: one {left,right} ready/valid stream fanned out into two
// independently stalled output streams, each side buffered by its own FIFO.

module stream_split_fifo #(
  parameter int W  = 8,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [AW:0]   o_count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [AW:0]  w_count;
  logic         w_pop;

  // Extra pointer bit distinguishes full from empty; difference is occupancy.
  assign w_count = r_wr - r_rd;
  assign o_count = w_count;
  assign o_valid = (w_count != '0);
  assign o_full  = (w_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

module stream_split #(
  parameter int LEFT_WIDTH   = 8,
  parameter int RIGHT_WIDTH  = 8,
  parameter int FIFO_ADDR_SZ = 1,
  parameter int IN_WIDTH     = LEFT_WIDTH + RIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [IN_WIDTH-1:0]     i_data,
  output logic                    o_left_valid,
  input  logic                    o_left_ready,
  output logic [LEFT_WIDTH-1:0]   o_left_data,
  output logic                    o_right_valid,
  input  logic                    o_right_ready,
  output logic [RIGHT_WIDTH-1:0]  o_right_data,
  output logic [FIFO_ADDR_SZ:0]   o_left_count,
  output logic [FIFO_ADDR_SZ:0]   o_right_count
);
  logic w_left_full;
  logic w_right_full;
  logic w_accept;

  // Ready depends only on registered occupancy (and reset), never on consumers.
  assign i_ready  = reset_n && !w_left_full && !w_right_full;
  assign w_accept = i_valid && i_ready;

  stream_split_fifo #(.W(LEFT_WIDTH), .AW(FIFO_ADDR_SZ)) u_left (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_data  (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
    .i_pop   (o_left_ready),
    .o_data  (o_left_data),
    .o_valid (o_left_valid),
    .o_full  (w_left_full),
    .o_count (o_left_count)
  );

  stream_split_fifo #(.W(RIGHT_WIDTH), .AW(FIFO_ADDR_SZ)) u_right (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_data  (i_data[RIGHT_WIDTH-1:0]),
    .i_pop   (o_right_ready),
    .o_data  (o_right_data),
    .o_valid (o_right_valid),
    .o_full  (w_right_full),
    .o_count (o_right_count)
  );
endmodule

// File: tb/tb_stream_split.sv
// Bench for stream_split: directed scenarios plus a queue-based scoreboard
// that tracks every accepted beat on both sides.

module tb_stream_split;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        o_left_valid, o_left_ready;
  logic [7:0]  o_left_data;
  logic        o_right_valid, o_right_ready;
  logic [7:0]  o_right_data;
  logic [1:0]  o_left_count, o_right_count;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] lq[$];
  logic [7:0] rq[$];

  always #5 clk = ~clk;

  stream_split #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .FIFO_ADDR_SZ(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_data        (i_data),
    .o_left_valid  (o_left_valid),
    .o_left_ready  (o_left_ready),
    .o_left_data   (o_left_data),
    .o_right_valid (o_right_valid),
    .o_right_ready (o_right_ready),
    .o_right_data  (o_right_data),
    .o_left_count  (o_left_count),
    .o_right_count (o_right_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model is two queues of accepted slices; occupancy, validity,
  // head data and ready all follow from queue sizes and the depth of 2.
  always @(negedge clk) begin
    if (!reset_n) begin
      lq.delete();
      rq.delete();
    end else begin
      chk("sb_lcnt", 32'(o_left_count), 32'(lq.size()));
      chk("sb_rcnt", 32'(o_right_count), 32'(rq.size()));
      chk("sb_lcnt_le2", 32'(o_left_count <= 2'd2), 32'd1);
      chk("sb_rcnt_le2", 32'(o_right_count <= 2'd2), 32'd1);
      chk("sb_irdy", 32'(i_ready), 32'(lq.size() < 2 && rq.size() < 2));
      chk("sb_lvld", 32'(o_left_valid), 32'(lq.size() != 0));
      chk("sb_rvld", 32'(o_right_valid), 32'(rq.size() != 0));
      if (lq.size() != 0) chk("sb_ldata", 32'(o_left_data), 32'(lq[0]));
      else                chk("sb_ldata_zero", 32'(o_left_data), 32'd0);
      if (rq.size() != 0) chk("sb_rdata", 32'(o_right_data), 32'(rq[0]));
      else                chk("sb_rdata_zero", 32'(o_right_data), 32'd0);
      if (o_left_valid && o_left_ready && lq.size() != 0)   void'(lq.pop_front());
      if (o_right_valid && o_right_ready && rq.size() != 0) void'(rq.pop_front());
      if (i_valid && i_ready) begin
        lq.push_back(i_data[15:8]);
        rq.push_back(i_data[7:0]);
      end
    end
  end

  logic [15:0] first_beat;

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    o_left_ready = 1'b0;
    o_right_ready = 1'b0;
    #1;
    chk("rst_irdy", 32'(i_ready), 32'd0);
    chk("rst_lvld", 32'(o_left_valid), 32'd0);
    chk("rst_rvld", 32'(o_right_valid), 32'd0);
    chk("rst_lcnt", 32'(o_left_count), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst_irdy", 32'(i_ready), 32'd1);
    chk("post_rst_lvld", 32'(o_left_valid), 32'd0);

    // Single beat, both consumers ready
    o_left_ready = 1'b1;
    o_right_ready = 1'b1;
    i_valid = 1'b1;
    i_data = 16'hA15B;
    tick();
    i_valid = 1'b0;
    chk("single_ldata", 32'(o_left_data), 32'hA1);
    chk("single_rdata", 32'(o_right_data), 32'h5B);
    chk("single_lvld", 32'(o_left_valid), 32'd1);
    chk("single_rvld", 32'(o_right_valid), 32'd1);
    tick();
    chk("single_lvld_after", 32'(o_left_valid), 32'd0);
    chk("single_rvld_after", 32'(o_right_valid), 32'd0);

    // Streaming, 20 beats back to back
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'b1;
      i_data = {8'(k + 1), 8'(k)};
      chk("stream_irdy", 32'(i_ready), 32'd1);
      if (k > 0) chk("stream_lvld", 32'(o_left_valid), 32'd1);
      tick();
    end
    i_valid = 1'b0;
    repeat (2) tick();

    // Skew: right stalled, left flowing
    o_right_ready = 1'b0;
    o_left_ready = 1'b1;
    i_valid = 1'b1;
    i_data = 16'h1122;
    tick();
    i_data = 16'h3344;
    tick();
    tick();
    chk("skew_rcnt", 32'(o_right_count), 32'd2);
    chk("skew_irdy", 32'(i_ready), 32'd0);
    chk("skew_lcnt", 32'(o_left_count), 32'd0);
    o_right_ready = 1'b1;
    tick();
    o_right_ready = 1'b0;
    i_valid = 1'b0;
    chk("skew_rcnt_pop", 32'(o_right_count), 32'd1);
    chk("skew_irdy_pop", 32'(i_ready), 32'd1);
    o_right_ready = 1'b1;
    repeat (3) tick();

    // Full stall: both consumers blocked
    o_left_ready = 1'b0;
    o_right_ready = 1'b0;
    first_beat = 16'hC3D4;
    i_valid = 1'b1;
    i_data = first_beat;
    tick();
    i_data = 16'hE5F6;
    tick();
    i_valid = 1'b0;
    chk("full_lcnt", 32'(o_left_count), 32'd2);
    chk("full_rcnt", 32'(o_right_count), 32'd2);
    chk("full_irdy", 32'(i_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk("full_ldata_hold", 32'(o_left_data), 32'(first_beat[15:8]));
      chk("full_rdata_hold", 32'(o_right_data), 32'(first_beat[7:0]));
      tick();
    end

    // Mid-stream reset while full
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_lvld", 32'(o_left_valid), 32'd0);
    chk("mrst_rvld", 32'(o_right_valid), 32'd0);
    chk("mrst_lcnt", 32'(o_left_count), 32'd0);
    chk("mrst_rcnt", 32'(o_right_count), 32'd0);
    chk("mrst_ldata", 32'(o_left_data), 32'd0);
    chk("mrst_rdata", 32'(o_right_data), 32'd0);
    chk("mrst_irdy", 32'(i_ready), 32'd0);
    tick();
    chk("mrst_irdy_hold", 32'(i_ready), 32'd0);
    reset_n = 1'b1;
    o_left_ready = 1'b1;
    o_right_ready = 1'b1;
    i_valid = 1'b1;
    i_data = 16'h7788;
    tick();
    i_valid = 1'b0;
    chk("mrst_new_ldata", 32'(o_left_data), 32'h77);
    chk("mrst_new_rdata", 32'(o_right_data), 32'h88);
    chk("mrst_new_lcnt", 32'(o_left_count), 32'd1);
    tick();
    chk("mrst_no_stale_l", 32'(o_left_valid), 32'd0);
    chk("mrst_no_stale_r", 32'(o_right_valid), 32'd0);

    // Random stalls on all three handshakes
    for (int c = 0; c < 1000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data = 16'($urandom);
      o_left_ready = ($urandom_range(0, 3) != 0);
      o_right_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Drain, bounded
    i_valid = 1'b0;
    o_left_ready = 1'b1;
    o_right_ready = 1'b1;
    for (int c = 0; c < 20 && (o_left_valid || o_right_valid); c++) tick();
    chk("drain_lvld", 32'(o_left_valid), 32'd0);
    chk("drain_rvld", 32'(o_right_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("drain_lq_empty", 32'(lq.size()), 32'd0);
    chk("drain_rq_empty", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
